ubcss_seq_sub: RTL
==================

UBCSS_SEQ_SUB -- requirements
Module: ubcss_seq_sub

Interface
REQ-001 The block SHALL have parameter BPC, default 1, giving borrow-select blocks resolved per cycle; legal values are 1, 3 and 9.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state is rising-edge.
REQ-003 The block SHALL have port RST, input, 1 bit, reset; RST is asynchronous and active-high.
REQ-004 The block SHALL have port IN_VALID, input, 1 bit, meaning operands are offered.
REQ-005 The block SHALL have port IN_READY, output, 1 bit, meaning the block can accept operands.
REQ-006 The block SHALL have port X, input, 30 bits, the minuend.
REQ-007 The block SHALL have port Y, input, 30 bits, the subtrahend.
REQ-008 The block SHALL have port OUT_VALID, output, 1 bit, meaning the result is valid.
REQ-009 The block SHALL have port OUT_READY, input, 1 bit, meaning the consumer accepts the result.
REQ-010 The block SHALL have port D, output, 30 bits, the difference X-Y mod 2^30.
REQ-011 The block SHALL have port BO, output, 1 bit, the borrow out; BO=1 iff unsigned X<Y.
REQ-012 The block SHALL have port OVF, output, 1 bit, the signed overflow flag; OVF exists only under UBCSS_OVF_EN.

Function
REQ-013 The block SHALL use the fixed partition of 9 blocks, in bits: [0], [1], [3:2], [6:4], [10:7], [15:11], [21:16], [28:22], [29].
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; IN_READY SHALL be 1 only in IDLE.
REQ-015 In IDLE, IN_VALID=1 SHALL capture X and Y, clear the borrow register and block index, and move to BUSY.
REQ-016 Each BUSY cycle SHALL resolve BPC consecutive blocks: each block computes its difference for borrow-in 0 and borrow-in 1, and the registered borrow selects between them.
REQ-017 Each resolved block SHALL write its bits of D and update the borrow register.
REQ-018 After the last block the FSM SHALL enter DONE with OUT_VALID=1.
REQ-019 Latency SHALL be: operands accepted at edge t give OUT_VALID high after edge t+9/BPC.
REQ-020 In DONE, D, BO and OVF SHALL hold stable until OUT_READY=1; on that edge the FSM SHALL return to IDLE.
REQ-021 The minimum accept-to-accept interval SHALL be 9/BPC+2 cycles.
REQ-022 IN_VALID SHALL be ignored outside IDLE, and captured operands SHALL NOT change while BUSY.
REQ-023 D bits of blocks not yet resolved SHALL read 0 during BUSY; only DONE values are meaningful.
REQ-024 BO SHALL be the complement of the carry out of X + ~Y + 1.

Reset
REQ-025 When RST is asserted, asynchronously: state=IDLE, IN_READY=1, OUT_VALID=0, D=0, BO=0, OVF=0, borrow=0, index=0.
REQ-026 Reset mid-BUSY or mid-DONE SHALL abandon the operation with no output handshake.

Configuration
REQ-027 With macro UBCSS_OVF_EN defined, OVF SHALL equal (X[29]!=Y[29]) & (D[29]!=X[29]), registered with D.
REQ-028 With UBCSS_OVF_EN undefined, the OVF port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package ubcss_pkg SHALL hold the width constant (30), block count (9), the block low/high bit tables, and the FSM state typedef.
REQ-030 One combinational sub-module, ubcss_bsel_blk, SHALL implement the dual-ripple borrow-select block; it is instantiated BPC times with a runtime bit slice.

Verification
REQ-031 X=5, Y=3 (BPC=1) -> D=2, BO=0, OVF=0, OUT_VALID 9 cycles after accept.
REQ-032 X=0, Y=1 -> D=0x3FFFFFFF, BO=1, OVF=0.
REQ-033 X=0x20000000, Y=1 -> D=0x1FFFFFFF, BO=0, OVF=1 (under UBCSS_OVF_EN).
REQ-034 OUT_READY held low 5 cycles in DONE -> D/BO stable and IN_READY=0; release -> IDLE next cycle and a back-to-back op is accepted.
REQ-035 RST pulsed at BUSY cycle 4 -> OUT_VALID=0 and IN_READY=1 immediately; the next op X=0x3FFFFFFF, Y=0x15555555 -> D=0x2AAAAAAA, BO=0.
REQ-036 BPC=3 and BPC=9 with the same vectors -> identical results at latency 3 and 1.

Source files
------------

// File: rtl/ubcss_pkg.sv
// Shared constants for the sequential borrow-select subtractor: operand width,
// the fixed 9-block partition and the control FSM state type.
package ubcss_pkg;

  localparam int UBCSS_W    = 30;
  localparam int UBCSS_NBLK = 9;
  localparam int UBCSS_MAXW = 7;

  // Low/high bit of each block; widths 1,1,2,3,4,5,6,7,1.
  localparam logic [4:0] UBCSS_BLK_LO [UBCSS_NBLK] =
    '{5'd0, 5'd1, 5'd2, 5'd4, 5'd7, 5'd11, 5'd16, 5'd22, 5'd29};
  localparam logic [4:0] UBCSS_BLK_HI [UBCSS_NBLK] =
    '{5'd0, 5'd1, 5'd3, 5'd6, 5'd10, 5'd15, 5'd21, 5'd28, 5'd29};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ubcss_state_t;

  function automatic logic [2:0] blk_msb(input logic [3:0] blk);
    return 3'(UBCSS_BLK_HI[blk] - UBCSS_BLK_LO[blk]);
  endfunction

endpackage

// File: rtl/ubcss_bsel_blk.sv
// Dual-ripple borrow-select block: differences and borrow-outs of one block
// for borrow-in 0 and 1. Bits above msb are forced to zero.
module ubcss_bsel_blk
  import ubcss_pkg::*;
(
  input  logic [UBCSS_MAXW-1:0] x,
  input  logic [UBCSS_MAXW-1:0] y,
  input  logic [2:0]            msb,
  output logic [UBCSS_MAXW-1:0] d0,
  output logic [UBCSS_MAXW-1:0] d1,
  output logic                  b0,
  output logic                  b1
);

  always_comb begin
    logic r0;
    logic r1;
    r0 = 1'b0;
    r1 = 1'b1;
    d0 = '0;
    d1 = '0;
    for (int i = 0; i < UBCSS_MAXW; i++) begin
      if (3'(i) <= msb) begin
        d0[i] = x[i] ^ y[i] ^ r0;
        d1[i] = x[i] ^ y[i] ^ r1;
        r0    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & r0);
        r1    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & r1);
      end
    end
    b0 = r0;
    b1 = r1;
  end

endmodule

// File: rtl/ubcss_seq_sub.sv
// Sequential 30-bit subtractor resolving BPC borrow-select blocks per cycle.
// Optional signed overflow output enabled by macro UBCSS_OVF_EN.
module ubcss_seq_sub
  import ubcss_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [UBCSS_W-1:0] X,
  input  logic [UBCSS_W-1:0] Y,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [UBCSS_W-1:0] D,
`ifdef UBCSS_OVF_EN
  output logic               BO,
  output logic               OVF
`else
  output logic               BO
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(UBCSS_NBLK - BPC);
  localparam logic [3:0] STEP     = 4'(BPC);

  ubcss_state_t       state;
  logic [UBCSS_W-1:0] x_r;
  logic [UBCSS_W-1:0] y_r;
  logic               borrow_r;
  logic [3:0]         idx_r;

  logic [4:0]            lo_k  [BPC];
  logic [2:0]            msb_k [BPC];
  logic [UBCSS_MAXW-1:0] xs_k  [BPC];
  logic [UBCSS_MAXW-1:0] ys_k  [BPC];
  logic [UBCSS_MAXW-1:0] d0_k  [BPC];
  logic [UBCSS_MAXW-1:0] d1_k  [BPC];
  logic                  b0_k  [BPC];
  logic                  b1_k  [BPC];

  logic [UBCSS_W-1:0] d_next;
  logic               borrow_next;

`ifdef UBCSS_OVF_EN
  function automatic logic ovf_f(input logic xs, input logic ys, input logic ds);
    return (xs != ys) && (ds != xs);
  endfunction
`endif

  // Stage: slice out the BPC blocks addressed by the block index.
  always_comb begin
    logic [3:0] blk;
    for (int k = 0; k < BPC; k++) begin
      blk = idx_r + 4'(k);
      if (blk > 4'(UBCSS_NBLK - 1)) blk = 4'(UBCSS_NBLK - 1);
      lo_k[k]  = UBCSS_BLK_LO[blk];
      msb_k[k] = blk_msb(blk);
      xs_k[k]  = UBCSS_MAXW'(x_r >> lo_k[k]);
      ys_k[k]  = UBCSS_MAXW'(y_r >> lo_k[k]);
    end
  end

  for (genvar k = 0; k < BPC; k++) begin : g_blk
    ubcss_bsel_blk u_blk (
      .x   (xs_k[k]),
      .y   (ys_k[k]),
      .msb (msb_k[k]),
      .d0  (d0_k[k]),
      .d1  (d1_k[k]),
      .b0  (b0_k[k]),
      .b1  (b1_k[k])
    );
  end

  // Stage: borrow selects each block's pre-computed result in order.
  always_comb begin
    logic b;
    b      = borrow_r;
    d_next = D;
    for (int k = 0; k < BPC; k++) begin
      d_next = d_next | (UBCSS_W'(b ? d1_k[k] : d0_k[k]) << lo_k[k]);
      b      = b ? b1_k[k] : b0_k[k];
    end
    borrow_next = b;
  end

  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && IN_VALID) begin
      x_r <= X;
      y_r <= Y;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      D         <= '0;
      BO        <= 1'b0;
      borrow_r  <= 1'b0;
      idx_r     <= '0;
`ifdef UBCSS_OVF_EN
      OVF       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            state    <= ST_BUSY;
            IN_READY <= 1'b0;
            D        <= '0;
            BO       <= 1'b0;
            borrow_r <= 1'b0;
            idx_r    <= '0;
`ifdef UBCSS_OVF_EN
            OVF      <= 1'b0;
`endif
          end
        end
        ST_BUSY: begin
          D        <= d_next;
          borrow_r <= borrow_next;
          if (idx_r == LAST_IDX) begin
            state     <= ST_DONE;
            OUT_VALID <= 1'b1;
            BO        <= borrow_next;
`ifdef UBCSS_OVF_EN
            OVF       <= ovf_f(x_r[UBCSS_W-1], y_r[UBCSS_W-1], d_next[UBCSS_W-1]);
`endif
          end else begin
            idx_r <= idx_r + STEP;
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state     <= ST_IDLE;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
